// File: rtl/xil_7s_dphy_pkg.sv
// Shared types and constants for the D-PHY HS lane byte aligner.
package xil_7s_dphy_pkg;

  localparam logic [7:0] DPHY_SYNC_BYTE = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HUNT,
    ST_LOCKED,
    ST_FAIL
  } hs_align_state_t;

  // True when b differs from the sync byte in exactly one bit position.
  function automatic logic one_bit_off(input logic [7:0] b);
    logic [7:0] d;
    d = b ^ DPHY_SYNC_BYTE;
    return (d != 8'h00) && ((d & (d - 8'd1)) == 8'h00);
  endfunction

endpackage

// File: rtl/xil_7s_dphy_sync_search.sv
// Combinational SoT sync search over a 16-bit window at all 8 bit offsets.
// XIL_7S_DPHY_SOT_TOL_EN adds single-bit-error tolerant matching.
module xil_7s_dphy_sync_search
  import xil_7s_dphy_pkg::*;
(
  input  logic [15:0] window,
  output logic        match,
  output logic [2:0]  offset,
  output logic        tol
);

  logic       exact_hit;
  logic [2:0] exact_k;

  // Descending scan so the lowest matching offset is the last one written.
  always_comb begin
    exact_hit = 1'b0;
    exact_k   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (window[k +: 8] == DPHY_SYNC_BYTE) begin
        exact_hit = 1'b1;
        exact_k   = 3'(k);
      end
    end
  end

`ifdef XIL_7S_DPHY_SOT_TOL_EN
  logic       tol_hit;
  logic [2:0] tol_k;

  always_comb begin
    tol_hit = 1'b0;
    tol_k   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (one_bit_off(window[k +: 8])) begin
        tol_hit = 1'b1;
        tol_k   = 3'(k);
      end
    end
  end

  // An exact hit at any offset outranks every tolerant hit.
  always_comb begin
    match  = exact_hit | tol_hit;
    offset = exact_hit ? exact_k : tol_k;
    tol    = ~exact_hit & tol_hit;
  end
`else
  always_comb begin
    match  = exact_hit;
    offset = exact_k;
    tol    = 1'b0;
  end
`endif

endmodule

// File: rtl/xil_7s_dphy_hs_byte_align.sv
// HS byte aligner for one D-PHY data lane: settle skip, SoT hunt, offset lock.
// XIL_7S_DPHY_SOT_TOL_EN enables locking on a sync byte with one bit error.
module xil_7s_dphy_hs_byte_align
  import xil_7s_dphy_pkg::*;
#(
  parameter int SKIP_BYTES   = 2,
  parameter int HUNT_TIMEOUT = 32
) (
  input  logic       byte_clk_i,
  input  logic       rst_n_i,
  input  logic       hs_en_i,
  input  logic [7:0] byte_data_i,
  output logic [7:0] byte_data_o,
  output logic       byte_valid_o,
  output logic       sync_found_o,
  output logic       sync_err_o,
  output logic       sot_err_o,
  output logic [2:0] offset_o
);

`ifdef XIL_7S_DPHY_SOT_TOL_EN
  localparam logic TOL_EN = 1'b1;
`else
  localparam logic TOL_EN = 1'b0;
`endif

  localparam logic [7:0] SKIP_LAST = (SKIP_BYTES > 0) ? 8'(SKIP_BYTES - 1) : 8'd0;
  localparam logic [7:0] HUNT_LAST = 8'(HUNT_TIMEOUT - 1);

  hs_align_state_t state;
  logic [7:0]      prev;
  logic [7:0]      cnt;
  logic [15:0]     window;
  logic [7:0]      aligned;
  logic            search_match;
  logic [2:0]      search_offset;
  logic            search_tol;

  assign window = {byte_data_i, prev};

  always_comb begin
    aligned = 8'(window >> offset_o);
  end

  xil_7s_dphy_sync_search u_search (
    .window (window),
    .match  (search_match),
    .offset (search_offset),
    .tol    (search_tol)
  );

  always_ff @(posedge byte_clk_i) begin
    if (!rst_n_i) begin
      state        <= ST_IDLE;
      prev         <= 8'h00;
      cnt          <= 8'h00;
      byte_data_o  <= 8'h00;
      byte_valid_o <= 1'b0;
      sync_found_o <= 1'b0;
      sync_err_o   <= 1'b0;
      sot_err_o    <= 1'b0;
      offset_o     <= 3'd0;
    end else begin
      prev         <= byte_data_i;
      byte_data_o  <= 8'h00;
      byte_valid_o <= 1'b0;
      sync_found_o <= 1'b0;
      sync_err_o   <= 1'b0;
      sot_err_o    <= 1'b0;

      // Leaving HS mode overrides whatever the current state would do.
      if (state != ST_IDLE && !hs_en_i) begin
        state <= ST_IDLE;
        cnt   <= 8'h00;
      end else begin
        case (state)
          ST_IDLE: begin
            if (hs_en_i) begin
              cnt   <= 8'h00;
              state <= (SKIP_BYTES == 0) ? ST_HUNT : ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (cnt == SKIP_LAST) begin
              cnt   <= 8'h00;
              state <= ST_HUNT;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ST_HUNT: begin
            if (search_match) begin
              offset_o     <= search_offset;
              sync_found_o <= 1'b1;
              sot_err_o    <= TOL_EN & search_tol;
              state        <= ST_LOCKED;
            end else if (cnt == HUNT_LAST) begin
              sync_err_o <= 1'b1;
              state      <= ST_FAIL;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ST_LOCKED: begin
            byte_data_o  <= aligned;
            byte_valid_o <= 1'b1;
          end
          ST_FAIL: begin
            state <= ST_FAIL;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xil_7s_dphy_hs_byte_align.sv
// Self-checking bench for xil_7s_dphy_hs_byte_align with a burst-level reference model.
module tb_xil_7s_dphy_hs_byte_align;

  localparam int SKIP = 2;
  localparam int TMO  = 32;
  localparam int MAXN = 256;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs_en = 1'b0;
  logic [7:0] din   = 8'h00;
  logic [7:0] dout;
  logic       valid, found, serr, soterr;
  logic [2:0] off;

  int checks = 0;
  int errors = 0;

  logic [7:0] bq [MAXN];
  int         blen;
  logic [7:0] pq [$];

  logic [7:0] e_data  [MAXN];
  logic       e_valid [MAXN];
  logic       e_found [MAXN];
  logic       e_err   [MAXN];
  logic       e_sot   [MAXN];
  logic [2:0] e_off   [MAXN];
  logic [2:0] m_off = 3'd0;

  always #5 clk = ~clk;

  xil_7s_dphy_hs_byte_align #(.SKIP_BYTES(SKIP), .HUNT_TIMEOUT(TMO)) dut (
    .byte_clk_i   (clk),
    .rst_n_i      (rst_n),
    .hs_en_i      (hs_en),
    .byte_data_i  (din),
    .byte_data_o  (dout),
    .byte_valid_o (valid),
    .sync_found_o (found),
    .sync_err_o   (serr),
    .sot_err_o    (soterr),
    .offset_o     (off)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lowest exact offset wins; tolerant (1-bit error) only when no exact hit anywhere.
  function automatic void find_sync(input logic [15:0] w, output logic hit,
                                    output logic [2:0] k, output logic tol);
    logic [7:0] c;
    hit = 1'b0; k = 3'd0; tol = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c = 8'(w >> i);
      if (!hit && c == 8'hB8) begin hit = 1'b1; k = 3'(i); end
    end
`ifdef XIL_7S_DPHY_SOT_TOL_EN
    for (int i = 0; i < 8; i++) begin
      c = 8'(w >> i);
      if (!hit && $countones(c ^ 8'hB8) == 1) begin hit = 1'b1; tol = 1'b1; k = 3'(i); end
    end
`endif
  endfunction

  // Expected outputs after edges s..n-1 for an HS burst whose entry cycle is s.
  task automatic model_burst(input int s, input int n);
    int         lock_t;
    logic       hit, tol;
    logic [2:0] k, lk;
    logic [15:0] w;
    lock_t = -1; lk = 3'd0;
    for (int c = s; c < n; c++) begin
      e_valid[c] = 1'b0; e_found[c] = 1'b0; e_err[c] = 1'b0;
      e_sot[c] = 1'b0; e_data[c] = 8'h00; e_off[c] = m_off;
    end
    for (int i = s + SKIP + 1; i <= s + SKIP + TMO && i < n && lock_t < 0; i++) begin
      find_sync({bq[i], bq[i-1]}, hit, k, tol);
      if (hit) begin
        lock_t = i; lk = k;
        e_found[i] = 1'b1; e_sot[i] = tol;
      end
    end
    if (lock_t >= 0) begin
      m_off = lk;
      for (int c = lock_t; c < n; c++) e_off[c] = lk;
      for (int j = lock_t + 1; j < n; j++) begin
        w = {bq[j], bq[j-1]};
        e_valid[j] = 1'b1;
        e_data[j]  = 8'(w >> lk);
      end
    end else if (s + SKIP + TMO <= n - 1) begin
      e_err[s + SKIP + TMO] = 1'b1;
    end
  endtask

  // Append pq as a bitstream delayed by k bits (earliest bit = bit 0).
  task automatic emit_shifted(input int k);
    logic [15:0] t;
    logic [7:0]  prv, cur;
    prv = 8'h00;
    for (int i = 0; i <= pq.size(); i++) begin
      cur = (i < pq.size()) ? pq[i] : 8'h00;
      t = {cur, prv} << k;
      bq[blen] = t[15:8];
      blen++;
      prv = cur;
    end
    pq.delete();
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk); hs_en = 1'b0; din = 8'($urandom);
      @(posedge clk); #1;
      chk("idle_valid", {7'd0, valid}, 8'h00);
      chk("idle_found", {7'd0, found}, 8'h00);
      chk("idle_err", {7'd0, serr}, 8'h00);
      chk("idle_sot", {7'd0, soterr}, 8'h00);
      chk("idle_off", {5'd0, off}, {5'd0, m_off});
    end
  endtask

  task automatic run_burst(input int rst_at);
    if (rst_at < 0) begin
      model_burst(0, blen);
    end else begin
      model_burst(0, rst_at);
      e_valid[rst_at] = 1'b0; e_found[rst_at] = 1'b0; e_err[rst_at] = 1'b0;
      e_sot[rst_at] = 1'b0; e_data[rst_at] = 8'h00; e_off[rst_at] = 3'd0;
      m_off = 3'd0;
      model_burst(rst_at + 1, blen);
    end
    for (int c = 0; c < blen; c++) begin
      @(negedge clk); hs_en = 1'b1; din = bq[c]; rst_n = (c == rst_at) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      chk("valid", {7'd0, valid}, {7'd0, e_valid[c]});
      chk("found", {7'd0, found}, {7'd0, e_found[c]});
      chk("sync_err", {7'd0, serr}, {7'd0, e_err[c]});
      chk("sot_err", {7'd0, soterr}, {7'd0, e_sot[c]});
      chk("offset", {5'd0, off}, {5'd0, e_off[c]});
      if (e_valid[c] || c == rst_at) chk("data", dout, e_data[c]);
    end
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(2);
  endtask

  initial begin
    int n, k;
    // Reset state
    rst_n = 1'b0; hs_en = 1'b0; din = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", dout, 8'h00);
    chk("rst_valid", {7'd0, valid}, 8'h00);
    chk("rst_found", {7'd0, found}, 8'h00);
    chk("rst_err", {7'd0, serr}, 8'h00);
    chk("rst_sot", {7'd0, soterr}, 8'h00);
    chk("rst_off", {5'd0, off}, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(2);

    // Aligned sync, payload 11 22 33
    blen = 0; bq[blen++] = 8'h00; bq[blen++] = 8'h00;
    pq = '{8'hB8, 8'h11, 8'h22, 8'h33}; emit_shifted(0);
    run_burst(-1);
    chk("aligned_off", {5'd0, off}, 8'd0);

    // Offset 3, payload A5 3C
    blen = 0; bq[blen++] = 8'h00; bq[blen++] = 8'h00;
    pq = '{8'hB8, 8'hA5, 8'h3C}; emit_shifted(3);
    run_burst(-1);
    chk("offset3_off", {5'd0, off}, 8'd3);

    // Timeout on an all-zero burst
    blen = 0; for (int i = 0; i < SKIP + TMO + 6; i++) bq[blen++] = 8'h00;
    run_burst(-1);
    chk("timeout_off_held", {5'd0, off}, 8'd3);

    // Locked burst cut short, then re-entry with sync at offset 5
    blen = 0; bq[blen++] = 8'h00; bq[blen++] = 8'h00;
    pq = '{8'hB8, 8'hC3, 8'h96, 8'h0F, 8'hF0}; emit_shifted(2);
    run_burst(-1);
    blen = 0; bq[blen++] = 8'h00; bq[blen++] = 8'h00;
    pq = '{8'hB8, 8'h5A, 8'hE7}; emit_shifted(5);
    run_burst(-1);
    chk("reentry_off", {5'd0, off}, 8'd5);

    // B9 at offset 0: tolerant lock or timeout depending on build
    blen = 0; bq[blen++] = 8'h00; bq[blen++] = 8'h00;
    bq[blen++] = 8'hB9; bq[blen++] = 8'h44; bq[blen++] = 8'h55;
    for (int i = 0; i < SKIP + TMO + 2; i++) bq[blen++] = 8'h00;
    run_burst(-1);
`ifdef XIL_7S_DPHY_SOT_TOL_EN
    chk("b9_off", {5'd0, off}, 8'd0);
`else
    chk("b9_off_held", {5'd0, off}, 8'd5);
`endif

    // Reset while locked with hs_en held high, then relock at offset 4
    blen = 0; bq[blen++] = 8'h00; bq[blen++] = 8'h00;
    pq = '{8'hB8, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}; emit_shifted(1);
    pq = '{8'hB8, 8'h77, 8'h88, 8'h99}; emit_shifted(4);
    run_burst(6);
    chk("rst_relock_off", {5'd0, off}, 8'd4);

    // Randomized bursts
    for (int it = 0; it < 30; it++) begin
      blen = 0;
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) bq[blen++] = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, 7);
        pq.push_back(8'hB8);
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) pq.push_back(8'($urandom));
        emit_shifted(k);
      end
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(30, 45) : $urandom_range(0, 10);
      for (int i = 0; i < n; i++) bq[blen++] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      if (blen < 2) bq[blen++] = 8'($urandom);
      run_burst(-1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
